shift_normalizer: RTL and testbench

//   Inverse companion of the barrel shifter: takes a word, finds the left-shift amount that

---
 rtl/shift_normalizer_pkg.sv | 16 +
 rtl/shift_normalizer_norm_stage.sv | 42 ++++
 rtl/shift_normalizer.sv | 134 +++++++++++++
 tb/tb_shift_normalizer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_normalizer_pkg.sv
// Shared definitions for the normalizer / barrel-shifter datapath.
//   state_t        : normalizer FSM states
//   DWIDTH_DEF     : default data width, shared with the barrel shifter
//   SHIFT_NUM_DEF  : default shift-amount width (log2 of DWIDTH_DEF)
package shift_normalizer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int unsigned DWIDTH_DEF    = 16;
   localparam int unsigned SHIFT_NUM_DEF = 4;

endpackage

// File: rtl/shift_normalizer_norm_stage.sv
// One binary-search stage of the normalizer (purely combinational).
// Stage amount is s = 2**cnt. Logical mode hits when the top s bits are
// zero; arithmetic mode hits when the top s+1 bits all equal the sign bit.
// On a hit the word is shifted left by s (zero fill at the LSB).
//   work    : current working word
//   cnt     : stage index (selects s)
//   arith   : 1 = redundant-sign-bit test, 0 = leading-zero test
//   shifted : work shifted by s on a hit, otherwise work unchanged
//   amt     : the stage amount s
//   hit     : stage test passed
module shift_normalizer_norm_stage #(
   parameter int unsigned DWIDTH    = 16,
   parameter int unsigned SHIFT_NUM = 4,
   parameter int unsigned CNT_W     = 2
) (
   input  logic [DWIDTH-1:0]    work,
   input  logic [CNT_W-1:0]     cnt,
   input  logic                 arith,
   output logic [DWIDTH-1:0]    shifted,
   output logic [SHIFT_NUM-1:0] amt,
   output logic                 hit
);

   localparam logic [DWIDTH-1:0] ONES = '1;

   logic [DWIDTH-1:0] mask_s;
   logic [DWIDTH-1:0] mask_s1;

   always_comb begin
      amt     = SHIFT_NUM'(1) << cnt;
      // Masks selecting the top s and top s+1 bits of the word.
      mask_s  = ~(ONES >> amt);
      mask_s1 = ~(ONES >> (amt + SHIFT_NUM'(1)));
      if (arith) begin
         hit = (work & mask_s1) == (work[DWIDTH-1] ? mask_s1 : '0);
      end else begin
         hit = (work & mask_s) == '0;
      end
      shifted = hit ? (work << amt) : work;
   end

endmodule

// File: rtl/shift_normalizer.sv
// Iterative normalizer: finds the left shift that normalizes a word (MSB set,
// or redundant sign bits removed) using one binary-search stage per cycle.
// Handshake is valid/ready on both sides; one request in flight at a time.
// Optional feature macro: ARITH_NORM_EN adds arith_i for sign normalization.
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   in_valid   : request valid            in_ready  : accepting (IDLE only)
//   data_i     : word to normalize        arith_i   : sign mode (ARITH_NORM_EN)
//   out_valid  : result valid, held       out_ready : consumer accepts result
//   data_o     : normalized word          shamt_o   : left-shift applied
//   zero_o     : input was all-zero (or all-sign in arithmetic mode)
module shift_normalizer
   import shift_normalizer_pkg::*;
#(
   parameter int unsigned DWIDTH    = DWIDTH_DEF,
   parameter int unsigned SHIFT_NUM = SHIFT_NUM_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DWIDTH-1:0]    data_i,
`ifdef ARITH_NORM_EN
   input  logic                 arith_i,
`endif
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DWIDTH-1:0]    data_o,
   output logic [SHIFT_NUM-1:0] shamt_o,
   output logic                 zero_o
);

   localparam int unsigned CNT_W = (SHIFT_NUM > 1) ? $clog2(SHIFT_NUM) : 1;

   if (DWIDTH != (1 << SHIFT_NUM)) begin : g_bad_cfg
      $error("shift_normalizer: DWIDTH must equal 2**SHIFT_NUM");
   end

   state_t               state_q, state_d;
   logic [DWIDTH-1:0]    work_q;
   logic [SHIFT_NUM-1:0] acc_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 zero_q;
   logic                 arith_q;

   logic                 arith_in;
   logic                 in_zero;
   logic [DWIDTH-1:0]    stage_word;
   logic [SHIFT_NUM-1:0] stage_amt;
   logic                 stage_hit;

`ifdef ARITH_NORM_EN
   assign arith_in = arith_i;
`else
   assign arith_in = 1'b0;
`endif

   // All-sign input is the degenerate case in arithmetic mode.
   assign in_zero = (data_i == '0) || (arith_in && (data_i == '1));

   shift_normalizer_norm_stage #(
      .DWIDTH    (DWIDTH),
      .SHIFT_NUM (SHIFT_NUM),
      .CNT_W     (CNT_W)
   ) u_stage (
      .work    (work_q),
      .cnt     (cnt_q),
      .arith   (arith_q),
      .shifted (stage_word),
      .amt     (stage_amt),
      .hit     (stage_hit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      case (state_q)
         IDLE:    if (in_valid)       state_d = SHIFT;
         SHIFT:   if (cnt_q == '0)    state_d = DONE;
         DONE:    if (out_ready)      state_d = IDLE;
         default:                     state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         work_q  <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         zero_q  <= 1'b0;
         arith_q <= 1'b0;
         data_o  <= '0;
         shamt_o <= '0;
         zero_o  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  work_q  <= data_i;
                  acc_q   <= '0;
                  cnt_q   <= CNT_W'(SHIFT_NUM - 1);
                  zero_q  <= in_zero;
                  arith_q <= arith_in;
               end
            end
            SHIFT: begin
               work_q <= stage_word;
               if (stage_hit) begin
                  acc_q <= acc_q | stage_amt;
               end
               // Results are published only on the last stage, so the
               // outputs stay bit-stable outside the SHIFT->DONE transition.
               if (cnt_q == '0) begin
                  data_o  <= stage_word;
                  shamt_o <= acc_q | (stage_hit ? stage_amt : '0);
                  zero_o  <= zero_q;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_normalizer.sv
module tb_shift_normalizer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] data_i = '0;
`ifdef ARITH_NORM_EN
   logic        arith_i = 1'b0;
`endif
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] data_o;
   logic [3:0]  shamt_o;
   logic        zero_o;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   shift_normalizer #(.DWIDTH(16), .SHIFT_NUM(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_i    (data_i),
`ifdef ARITH_NORM_EN
      .arith_i   (arith_i),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_o    (data_o),
      .shamt_o   (shamt_o),
      .zero_o    (zero_o)
   );

   typedef struct {
      logic [15:0] d;
      bit          a;
      logic [15:0] exp_d;
      logic [3:0]  exp_sh;
      bit          exp_z;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // Reference: shift left one bit at a time until normalized.
   function automatic void ref_norm(input logic [15:0] d, input bit a,
                                    output logic [15:0] w, output logic [3:0] sh,
                                    output bit z);
      w  = d;
      sh = '0;
      while (sh < 4'd15 && (a ? (w[15] == w[14]) : !w[15])) begin
         w  = w << 1;
         sh = sh + 4'd1;
      end
      z = a ? (d == 16'h0000 || d == 16'hFFFF) : (d == 16'h0000);
   endfunction

   task automatic wait_idle();
      int n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) chk("idle_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_op(input string tag, input logic [15:0] d, input bit a,
                         input int stall, input logic [15:0] exp_d,
                         input logic [3:0] exp_sh, input bit exp_z);
      int lat;
      logic [15:0] d0;
      logic [3:0]  s0;
      logic        z0;
      bit          stable;
      wait_idle();
      in_valid = 1'b1;
      data_i   = d;
`ifdef ARITH_NORM_EN
      arith_i  = a;
`endif
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'd4);
      chk({tag, "_data"}, 32'(data_o), 32'(exp_d));
      chk({tag, "_shamt"}, 32'(shamt_o), 32'(exp_sh));
      chk({tag, "_zero"}, 32'(zero_o), 32'(exp_z));
      d0 = data_o; s0 = shamt_o; z0 = zero_o;
      stable = 1'b1;
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         if (!out_valid || data_o !== d0 || shamt_o !== s0 || zero_o !== z0 || in_ready)
            stable = 1'b0;
      end
      chk({tag, "_hold"}, 32'(stable), 32'd1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_post_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_post_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] md;
      logic [3:0]  ms;
      bit          mz;
      logic [15:0] rd;
      bit          ra;
      bit          seen;

      vecs.push_back('{16'h0001, 1'b0, 16'h8000, 4'd15, 1'b0});
      vecs.push_back('{16'h00F0, 1'b0, 16'hF000, 4'd8,  1'b0});
      vecs.push_back('{16'h8000, 1'b0, 16'h8000, 4'd0,  1'b0});
      vecs.push_back('{16'h0000, 1'b0, 16'h0000, 4'd15, 1'b1});
      vecs.push_back('{16'hFFFF, 1'b0, 16'hFFFF, 4'd0,  1'b0});
      vecs.push_back('{16'h0100, 1'b0, 16'h8000, 4'd7,  1'b0});
      vecs.push_back('{16'h0003, 1'b0, 16'hC000, 4'd14, 1'b0});
      vecs.push_back('{16'h4001, 1'b0, 16'h8002, 4'd1,  1'b0});
`ifdef ARITH_NORM_EN
      vecs.push_back('{16'hFFF0, 1'b1, 16'h8000, 4'd11, 1'b0});
      vecs.push_back('{16'hFFFF, 1'b1, 16'h8000, 4'd15, 1'b1});
      vecs.push_back('{16'h0000, 1'b1, 16'h0000, 4'd15, 1'b1});
      vecs.push_back('{16'h0001, 1'b1, 16'h4000, 4'd14, 1'b0});
      vecs.push_back('{16'h8000, 1'b1, 16'h8000, 4'd0,  1'b0});
      vecs.push_back('{16'h00F0, 1'b0, 16'hF000, 4'd8,  1'b0});
`endif

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(data_o), 32'd0);
      chk("rst_shamt", 32'(shamt_o), 32'd0);
      chk("rst_zero", 32'(zero_o), 32'd0);
      rst = 1'b0;

      foreach (vecs[i])
         run_op($sformatf("vec%0d", i), vecs[i].d, vecs[i].a, i % 3,
                vecs[i].exp_d, vecs[i].exp_sh, vecs[i].exp_z);

      // Back-pressure: result held for 5 cycles, new requests ignored
      wait_idle();
      in_valid = 1'b1;
      data_i   = 16'h00F0;
`ifdef ARITH_NORM_EN
      arith_i  = 1'b0;
`endif
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("bp_valid_rise", 32'(out_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         data_i   = 16'h1234;
         @(posedge clk); #1;
         chk($sformatf("bp_valid_%0d", i), 32'(out_valid), 32'd1);
         chk($sformatf("bp_in_ready_%0d", i), 32'(in_ready), 32'd0);
         chk($sformatf("bp_data_%0d", i), 32'(data_o), 32'h0000F000);
         chk($sformatf("bp_shamt_%0d", i), 32'(shamt_o), 32'd8);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_release_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk("bp_no_capture", 32'(in_ready), 32'd1);
      chk("bp_data_kept", 32'(data_o), 32'h0000F000);

      // Reset two cycles after accept aborts the operation
      wait_idle();
      in_valid = 1'b1;
      data_i   = 16'h0001;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_data", 32'(data_o), 32'd0);
      chk("abort_shamt", 32'(shamt_o), 32'd0);
      seen = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      chk("abort_no_valid", 32'(seen), 32'd0);
      run_op("after_abort", 16'h00F0, 1'b0, 0, 16'hF000, 4'd8, 1'b0);

      // Random sweep against the reference model
      for (int i = 0; i < 150; i++) begin
         rd = 16'($urandom) >> $urandom_range(0, 16);
         ra = 1'b0;
`ifdef ARITH_NORM_EN
         ra = 1'($urandom_range(0, 1));
         if (ra && $urandom_range(0, 1) == 1) rd = ~rd;
`endif
         ref_norm(rd, ra, md, ms, mz);
         run_op($sformatf("rnd%0d_%h", i, rd), rd, ra, int'($urandom_range(0, 2)), md, ms, mz);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
